// File: rtl/shiftregister_universal.sv
// Universal N-bit shift register: left/right/rotate/arithmetic shifts, parallel load,
// clock enable, and a shift counter that pulses word_done after every WIDTH shifts.
module shiftregister_universal #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                         clockpulse,
    input  logic                         clear,
    input  logic                         enable,
    input  logic [2:0]                   mode,
    input  logic                         serial_input_lsb,
    input  logic                         serial_input_msb,
    input  logic [WIDTH-1:0]             preset,
    output logic [WIDTH-1:0]             signal_q,
    output logic [WIDTH-1:0]             signal_q_,
    output logic                         serial_output_msb,
    output logic                         serial_output_lsb,
    output logic [$clog2(WIDTH+1)-1:0]   shift_count,
    output logic                         word_done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_SHL  = 3'd1,
        MODE_SHR  = 3'd2,
        MODE_ROL  = 3'd3,
        MODE_ROR  = 3'd4,
        MODE_LOAD = 3'd5,
        MODE_ASR  = 3'd6,
        MODE_ZERO = 3'd7
    } mode_e;

    mode_e            mode_sel;
    logic [WIDTH-1:0] next_q;
    logic             is_shift;
    logic             is_restart;

    assign mode_sel = mode_e'(mode);

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        next_q     = signal_q;
        is_shift   = 1'b0;
        is_restart = 1'b0;
        case (mode_sel)
            MODE_HOLD: next_q = signal_q;
            MODE_SHL: begin
                next_q   = {signal_q[WIDTH-2:0], serial_input_lsb};
                is_shift = 1'b1;
            end
            MODE_SHR: begin
                next_q   = {serial_input_msb, signal_q[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            MODE_ROL: begin
                next_q   = {signal_q[WIDTH-2:0], signal_q[WIDTH-1]};
                is_shift = 1'b1;
            end
            MODE_ROR: begin
                next_q   = {signal_q[0], signal_q[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            MODE_LOAD: begin
                next_q     = preset;
                is_restart = 1'b1;
            end
            MODE_ASR: begin
                next_q   = {signal_q[WIDTH-1], signal_q[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            MODE_ZERO: begin
                next_q     = '0;
                is_restart = 1'b1;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clockpulse) begin
        if (clear) begin
            signal_q    <= RESET_VALUE;
            shift_count <= '0;
            word_done   <= 1'b0;
        end else if (!enable) begin
            word_done <= 1'b0;
        end else begin
            signal_q <= next_q;
            if (is_shift) begin
                // The WIDTH-th shift wraps the count and flags the completed word.
                if (shift_count == LAST_SHIFT) begin
                    shift_count <= '0;
                    word_done   <= 1'b1;
                end else begin
                    shift_count <= shift_count + 1'b1;
                    word_done   <= 1'b0;
                end
            end else if (is_restart) begin
                shift_count <= '0;
                word_done   <= 1'b0;
            end else begin
                word_done <= 1'b0;
            end
        end
    end

    assign signal_q_         = ~signal_q;
    assign serial_output_msb = signal_q[WIDTH-1];
    assign serial_output_lsb = signal_q[0];

endmodule

// File: tb/tb_shiftregister_universal.sv
// Scoreboard bench: the driver pushes model predictions, a monitor pops and compares
// them one step after each rising edge.
module tb_shiftregister_universal;

    localparam int W    = 4;
    localparam int CW   = $clog2(W + 1);
    localparam int MASK = (1 << W) - 1;
    localparam int HALF = 1 << (W - 1);
    localparam int RV   = 0;

    logic          clockpulse = 1'b0;
    logic          clear = 1'b0;
    logic          enable = 1'b0;
    logic [2:0]    mode = 3'd0;
    logic          serial_input_lsb = 1'b0;
    logic          serial_input_msb = 1'b0;
    logic [W-1:0]  preset = '0;
    logic [W-1:0]  signal_q;
    logic [W-1:0]  signal_q_;
    logic          serial_output_msb;
    logic          serial_output_lsb;
    logic [CW-1:0] shift_count;
    logic          word_done;

    typedef struct {
        int q;
        int cnt;
        bit wd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_q    = RV;
    int   m_cnt  = 0;

    shiftregister_universal #(.WIDTH(W), .RESET_VALUE(W'(RV))) dut (
        .clockpulse        (clockpulse),
        .clear             (clear),
        .enable            (enable),
        .mode              (mode),
        .serial_input_lsb  (serial_input_lsb),
        .serial_input_msb  (serial_input_msb),
        .preset            (preset),
        .signal_q          (signal_q),
        .signal_q_         (signal_q_),
        .serial_output_msb (serial_output_msb),
        .serial_output_lsb (serial_output_lsb),
        .shift_count       (shift_count),
        .word_done         (word_done)
    );

    always #5 clockpulse = ~clockpulse;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and push the model's prediction for the following edge.
    task automatic step(input bit clr, input bit en, input int md, input bit sl,
                        input bit sm, input int pre);
        exp_t e;
        bit   wd;
        @(negedge clockpulse);
        clear            = clr;
        enable           = en;
        mode             = md[2:0];
        serial_input_lsb = sl;
        serial_input_msb = sm;
        preset           = pre[W-1:0];
        wd = 1'b0;
        if (clr) begin
            m_q   = RV;
            m_cnt = 0;
        end else if (en) begin
            case (md)
                1: m_q = ((m_q * 2) + int'(sl)) & MASK;
                2: m_q = (m_q / 2) + (sm ? HALF : 0);
                3: m_q = ((m_q * 2) & MASK) + ((m_q >= HALF) ? 1 : 0);
                4: m_q = (m_q / 2) + ((m_q % 2 == 1) ? HALF : 0);
                5: m_q = pre & MASK;
                6: m_q = (m_q / 2) + ((m_q >= HALF) ? HALF : 0);
                7: m_q = 0;
                default: ;
            endcase
            if (md inside {1, 2, 3, 4, 6}) begin
                m_cnt++;
                if (m_cnt == W) begin
                    m_cnt = 0;
                    wd    = 1'b1;
                end
            end else if (md == 5 || md == 7) begin
                m_cnt = 0;
            end
        end
        e.q   = m_q;
        e.cnt = m_cnt;
        e.wd  = wd;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clockpulse);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("signal_q", 32'(signal_q), 32'(e.q));
                check("signal_q_", 32'(signal_q_), 32'((~e.q) & MASK));
                check("serial_output_msb", 32'(serial_output_msb), 32'((e.q >> (W - 1)) & 1));
                check("serial_output_lsb", 32'(serial_output_lsb), 32'(e.q & 1));
                check("shift_count", 32'(shift_count), 32'(e.cnt));
                check("word_done", 32'(word_done), 32'(e.wd));
            end
        end
    end

    initial begin : driver
        int bits[4];
        // Reset
        step(1, 0, 0, 0, 0, 0);
        // Load then shift left
        step(0, 1, 5, 1, 1, 'b1011);
        step(0, 1, 1, 0, 1, 'b0101);
        // Rotate right and arithmetic shift right
        step(0, 1, 5, 0, 0, 'b1011);
        step(0, 1, 4, 1, 1, 'b0000);
        step(0, 1, 5, 0, 0, 'b1000);
        step(0, 1, 6, 1, 0, 'b1111);
        step(0, 1, 6, 0, 1, 'b1111);
        // Deserialize 1,0,1,1
        step(0, 1, 5, 0, 0, 'b0000);
        bits = '{1, 0, 1, 1};
        foreach (bits[i]) step(0, 1, 1, bits[i][0], 1, 'b1111);
        // Clear mid-word discards the partial count
        step(0, 1, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(1, 1, 1, 1, 1, 'b1111);
        for (int i = 0; i < 4; i++) step(0, 1, 2, i[0], 1, 0);
        // Enable gating and back-to-back word pulses across mixed directions
        step(0, 1, 5, 0, 0, 'b0110);
        step(0, 1, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 1, 'b1111);
        for (int i = 0; i < 9; i++) step(0, 1, 1 + (i % 4), i[1], i[0], 0);
        step(0, 1, 5, 0, 0, 'b1001);
        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 9) != 0),
                 int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, MASK)));
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clockpulse);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
